// File: rtl/led_frame_feeder.sv
// rtl/led_frame_feeder.sv - Pixel FIFO with frame-start pacing for a serial LED sender.
// Optional write-path brightness scaling: define LED_BRIGHT_SCALE_EN.
module led_frame_feeder #(
    parameter int LED_NUM     = 4,
    parameter int DEPTH       = 8,
    parameter int REFRESH_CNT = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [23:0]              pix_data,
    input  logic                     pix_vld,
    output logic                     pix_rdy,
    input  logic [7:0]               bright,
    input  logic                     rd,
    output logic [23:0]              fifo_data_out,
    output logic                     enable,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     ovf_err,
    output logic                     udf_err
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW  = $clog2(DEPTH) + 1;
    localparam int PCW = $clog2(LED_NUM + 1);
    localparam int TW  = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    localparam logic [FW-1:0]  FULL_LVL   = FW'(DEPTH);
    localparam logic [FW-1:0]  FRAME_LVL  = FW'(LED_NUM);
    localparam logic [PCW-1:0] POP_LAST   = PCW'(LED_NUM - 1);
    localparam logic [TW-1:0]  TIMER_INIT = TW'(REFRESH_CNT - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        START   = 2'd1,
        SENDING = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [PCW-1:0]  pop_cnt_q, pop_cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            expired_q, expired_d;
    logic            enable_q, enable_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    logic [23:0]     mem [DEPTH];
    logic [23:0]     wr_data;
    logic            empty, full, rd_req, pop, wr;

`ifdef LED_BRIGHT_SCALE_EN
    logic [15:0] prod_r, prod_g, prod_b;
    always_comb begin
        prod_r  = {8'd0, pix_data[7:0]}   * {8'd0, bright};
        prod_g  = {8'd0, pix_data[15:8]}  * {8'd0, bright};
        prod_b  = {8'd0, pix_data[23:16]} * {8'd0, bright};
        wr_data = {prod_b[15:8], prod_g[15:8], prod_r[15:8]};
    end
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign wr_data       = pix_data;
`endif

    assign empty  = (fill_q == '0);
    assign full   = (fill_q == FULL_LVL);
    assign rd_req = (state_q == SENDING) && rd;
    assign pop    = rd_req && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
    assign wr     = pix_vld && (!full || pop);

    always_comb begin
        state_d   = state_q;
        pop_cnt_d = pop_cnt_q;
        timer_d   = timer_q;
        expired_d = expired_q;
        ovf_d     = ovf_q | (pix_vld && full && !pop);
        udf_d     = udf_q | (rd_req && empty);
        wr_ptr_d  = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({wr, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        case (state_q)
            FILL: begin
                if (fill_q >= FRAME_LVL && expired_q) begin
                    state_d = START;
                end
            end
            START: begin
                state_d   = SENDING;
                pop_cnt_d = '0;
            end
            SENDING: begin
                // Every rd consumes a frame slot, even when it finds the FIFO empty.
                if (rd) begin
                    pop_cnt_d = pop_cnt_q + PCW'(1);
                    if (pop_cnt_q == POP_LAST) begin
                        state_d   = GAP;
                        timer_d   = TIMER_INIT;
                        expired_d = 1'b0;
                    end
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d   = FILL;
                    expired_d = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = FILL;
        endcase

        enable_d = (state_d == START);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FILL;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            pop_cnt_q <= '0;
            timer_q   <= '0;
            expired_q <= 1'b1;
            enable_q  <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            pop_cnt_q <= pop_cnt_d;
            timer_q   <= timer_d;
            expired_q <= expired_d;
            enable_q  <= enable_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign pix_rdy       = !full;
    assign fifo_data_out = empty ? 24'h0 : mem[rd_ptr_q];
    assign enable        = enable_q;
    assign fill_level    = fill_q;
    assign ovf_err       = ovf_q;
    assign udf_err       = udf_q;

endmodule

// File: tb/tb_led_frame_feeder.sv
// tb/tb_led_frame_feeder.sv - Directed and randomized checks of led_frame_feeder against a queue model.
module tb_led_frame_feeder;
    localparam int LED_NUM     = 4;
    localparam int DEPTH       = 8;
    localparam int REFRESH_CNT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_vld = 1'b0;
    logic        pix_rdy;
    logic [7:0]  bright = 8'hFF;
    logic        rd = 1'b0;
    logic [23:0] fifo_data_out;
    logic        enable;
    logic [3:0]  fill_level;
    logic        ovf_err;
    logic        udf_err;

    int checks = 0;
    int errors = 0;

    // Reference model: a word queue plus frame bookkeeping in cycles.
    logic [23:0] mq[$];
    bit m_en, m_busy, m_ovf, m_udf;
    int m_slots, m_quiet;

    led_frame_feeder #(.LED_NUM(LED_NUM), .DEPTH(DEPTH), .REFRESH_CNT(REFRESH_CNT)) dut (
        .clk(clk), .rstn(rstn), .pix_data(pix_data), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
        .bright(bright), .rd(rd), .fifo_data_out(fifo_data_out), .enable(enable),
        .fill_level(fill_level), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] scale(input logic [23:0] w, input logic [7:0] b);
`ifdef LED_BRIGHT_SCALE_EN
        int r, g, bl;
        r  = (int'(w[7:0])   * int'(b)) / 256;
        g  = (int'(w[15:8])  * int'(b)) / 256;
        bl = (int'(w[23:16]) * int'(b)) / 256;
        return {bl[7:0], g[7:0], r[7:0]};
`else
        return w + 24'(0 * b);
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_busy = 0; m_ovf = 0; m_udf = 0; m_slots = 0; m_quiet = 0;
    endtask

    task automatic model_edge(input bit vld, input logic [23:0] d, input bit r);
        int  pre = mq.size();
        bit  do_pop = 0;
        if (m_en) begin
            m_en = 0; m_busy = 1; m_slots = LED_NUM;
        end else if (m_busy) begin
            if (r) begin
                if (pre > 0) do_pop = 1; else m_udf = 1;
                m_slots--;
                if (m_slots == 0) begin
                    m_busy = 0; m_quiet = REFRESH_CNT;
                end
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (pre >= LED_NUM) begin
            m_en = 1;
        end
        if (do_pop) void'(mq.pop_front());
        if (vld) begin
            if (pre < DEPTH || do_pop) mq.push_back(scale(d, bright));
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        check("fill_level", 32'(fill_level), 32'(mq.size()));
        check("pix_rdy", 32'(pix_rdy), 32'(mq.size() < DEPTH));
        check("fifo_data_out", 32'(fifo_data_out), mq.size() > 0 ? 32'(mq[0]) : 32'h0);
        check("enable", 32'(enable), 32'(m_en));
        check("ovf_err", 32'(ovf_err), 32'(m_ovf));
        check("udf_err", 32'(udf_err), 32'(m_udf));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit vld, input logic [23:0] d, input bit r);
        pix_vld = vld; pix_data = d; rd = r;
        @(posedge clk);
        model_edge(vld, d, r);
        @(negedge clk);
        pix_vld = 0; rd = 0;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0; pix_vld = 0; rd = 0;
        #2;
        model_reset();
        check("rst_fill", 32'(fill_level), 32'h0);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_ovf", 32'(ovf_err), 32'h0);
        check("rst_udf", 32'(udf_err), 32'h0);
        @(negedge clk);
        rstn = 1;
        check("rst_pix_rdy", 32'(pix_rdy), 32'h1);
    endtask

    initial begin
        int n;
        // Single frame: enable timing, data order, ignored extra rd.
        do_reset();
        bright = 8'hFF;
        for (int i = 1; i <= 4; i++) cycle(1, 24'(i), 0);
        check("en_early", 32'(enable), 32'h0);
        cycle(0, 0, 0);
        check("en_lat", 32'(enable), 32'h1);
        check("head_first", 32'(fifo_data_out), 32'h1);
        cycle(0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            check("pop_order", 32'(fifo_data_out), 32'(k));
            cycle(0, 0, 1);
        end
        check("fill_after_frame", 32'(fill_level), 32'h0);
        cycle(0, 0, 1);
        check("gap_rd_ignored", 32'(udf_err), 32'h0);

        // Two buffered frames: refresh spacing and second-frame data.
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1, 24'(i), 0);
        for (int k = 1; k <= 4; k++) begin
            check("f1_data", 32'(fifo_data_out), 32'(k));
            cycle(0, 0, 1);
        end
        n = 0;
        while (!enable && n < 100) begin
            cycle(0, 0, 0);
            n++;
        end
        check("refresh_spacing", 32'(n), 32'(REFRESH_CNT + 1));
        check("f2_head", 32'(fifo_data_out), 32'h5);

        // Overflow: nine writes without reads.
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1, 24'(i + 32'h100), 0);
        check("full_rdy_low", 32'(pix_rdy), 32'h0);
        cycle(1, 24'h999, 0);
        check("ovf_set", 32'(ovf_err), 32'h1);
        check("full_level", 32'(fill_level), 32'd8);

        // Write-path brightness.
        do_reset();
        bright = 8'h80;
        cycle(1, 24'hFF4002, 0);
`ifdef LED_BRIGHT_SCALE_EN
        check("bright_80", 32'(fifo_data_out), 32'h7F2001);
`else
        check("bright_ignored", 32'(fifo_data_out), 32'hFF4002);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            if (c % 150 == 0) bright = 8'($urandom);
            cycle(($urandom % 100) < 55, 24'($urandom), ($urandom % 100) < 45);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
